// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the column generator path.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int LFSR_W = 6;

    // An all-zeros state would lock the LFSR, so this seed replaces it
    localparam logic [LFSR_W-1:0] SEED_FALLBACK = 6'b000001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEED    = 3'd1,
        STEP    = 3'd2,
        CAPTURE = 3'd3,
        WAIT    = 3'd4
    } feeder_state_t;

    typedef struct packed {
        logic [2:0] gap;
        logic [2:0] aux;
    } column_t;

endpackage
`default_nettype wire

// File: rtl/column_fifo.sv
`default_nettype none
// ============================================================================
// Module      : column_fifo
// Description : Power-of-two depth FIFO with flush; head held while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module column_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = DEPTH[c_ptr_w:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   r_last;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !flush && !empty;
    assign w_do_push = push && !flush && (!full || w_do_pop);

    // The last popped word stays visible so consumers see a stable value when empty
    assign pop_data  = empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : column_feeder
// Description : Seeds and steps the column LFSR, buffers mapped columns and
//               hands them out over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module column_feeder
    import game_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int STEPS_PER_COL = 3,
    parameter int GAP_MAX       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              restart,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              lfsr_random,
    output logic              lfsr_load,
    output logic [LFSR_W-1:0] lfsr_seed,
    input  logic [2:0]        first_column,
    input  logic [2:0]        second_column,
    output logic              col_valid,
    input  logic              col_ready,
    output logic [2:0]        col_gap,
    output logic [2:0]        col_aux,
    output logic              running
);

    localparam int c_step_w = $clog2(STEPS_PER_COL) + 1;
    localparam int c_cnt_w  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]          c_gap_max   = 4'(GAP_MAX);
    localparam logic [c_step_w-1:0] c_last_step = c_step_w'(STEPS_PER_COL - 1);
    localparam logic [c_cnt_w-1:0]  c_depth_m1  = c_cnt_w'(FIFO_DEPTH - 1);

    feeder_state_t       r_state;
    feeder_state_t       w_next_state;
    logic [c_step_w-1:0] r_step_cnt;
    logic [LFSR_W-1:0]   r_seed_cnt;
    logic [LFSR_W-1:0]   r_lfsr_seed;
    logic [LFSR_W-1:0]   w_seed_pick;
    logic [LFSR_W-1:0]   w_eff_seed;
    logic                w_restart;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_full_after;
    logic [c_cnt_w-1:0]  w_count;
    logic [3:0]          w_first_ext;
    column_t             w_push_col;
    column_t             w_head_col;

    assign w_restart    = restart && (r_state != IDLE);
    assign col_valid    = !w_empty;
    assign w_pop        = col_valid && col_ready && !w_restart;
    assign w_full_after = w_pop ? w_full : (w_count == c_depth_m1);
    assign col_gap      = w_head_col.gap;
    assign col_aux      = w_head_col.aux;
    assign running      = (r_state != IDLE);
    assign lfsr_seed    = r_lfsr_seed;

    assign w_seed_pick  = (seed_in != '0) ? seed_in : r_seed_cnt;
    assign w_eff_seed   = (w_seed_pick == '0) ? SEED_FALLBACK : w_seed_pick;

    // Out-of-range values fold back once; GAP_MAX >= 4 keeps the result in range
    assign w_first_ext  = {1'b0, first_column};
    always_comb begin
        w_push_col.aux = second_column;
        if (w_first_ext < c_gap_max) begin
            w_push_col.gap = first_column;
        end else begin
            w_push_col.gap = 3'(w_first_ext - c_gap_max);
        end
    end

    always_comb begin
        w_next_state = r_state;
        lfsr_random  = 1'b0;
        lfsr_load    = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !restart) begin
                    w_next_state = SEED;
                end
            end
            SEED: begin
                lfsr_load    = 1'b1;
                lfsr_random  = 1'b1;
                w_next_state = STEP;
            end
            STEP: begin
                lfsr_random = 1'b1;
                if (r_step_cnt == c_last_step) begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_push       = 1'b1;
                w_next_state = w_full_after ? WAIT : STEP;
            end
            WAIT: begin
                if (!w_full) begin
                    w_next_state = STEP;
                end
            end
            default: w_next_state = IDLE;
        endcase
        if (w_restart) begin
            w_next_state = SEED;
            w_push       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_step_cnt  <= '0;
            r_seed_cnt  <= '0;
            r_lfsr_seed <= '0;
        end else begin
            r_state    <= w_next_state;
            r_step_cnt <= ((r_state == STEP) && (w_next_state == STEP)) ?
                          r_step_cnt + 1'b1 : '0;
            if (r_state == IDLE) begin
                r_seed_cnt <= r_seed_cnt + 1'b1;
            end
            if ((r_state == IDLE) && (w_next_state == SEED)) begin
                r_lfsr_seed <= w_eff_seed;
            end
        end
    end

    column_fifo #(
        .WIDTH ($bits(column_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_restart),
        .push      (w_push),
        .push_data (w_push_col),
        .pop       (w_pop),
        .pop_data  (w_head_col),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_column_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_column_feeder
// Description : Self-checking bench for column_feeder with a 6-bit LFSR stub.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_column_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       restart = 1'b0;
    logic       col_ready = 1'b0;
    logic [5:0] seed_in = 6'd1;
    logic       lfsr_random, lfsr_load, col_valid, running;
    logic [5:0] lfsr_seed;
    logic [2:0] first_column, second_column, col_gap, col_aux;
    logic [5:0] lfsr_q;
    logic       force_en = 1'b0;
    logic [2:0] force_val = 3'd0;
    int         errors = 0;
    int         checks = 0;
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [5:0] lfsr_next(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    function automatic logic [2:0] gap_of(input logic [2:0] f);
        return (f < 3'd6) ? f : f - 3'd6;
    endfunction

    // LFSR stub: x^6 + x^5 + 1, shifting left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= '0;
        else if (lfsr_random) lfsr_q <= lfsr_load ? lfsr_seed : lfsr_next(lfsr_q);
    end
    assign first_column  = force_en ? force_val : lfsr_q[2:0];
    assign second_column = lfsr_q[5:3];

    column_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .restart       (restart),
        .seed_in       (seed_in),
        .lfsr_random   (lfsr_random),
        .lfsr_load     (lfsr_load),
        .lfsr_seed     (lfsr_seed),
        .first_column  (first_column),
        .second_column (second_column),
        .col_valid     (col_valid),
        .col_ready     (col_ready),
        .col_gap       (col_gap),
        .col_aux       (col_aux),
        .running       (running)
    );

    task automatic push_expected(input logic [5:0] seed, input int n);
        logic [5:0] s;
        s = seed;
        repeat (n) begin
            repeat (3) s = lfsr_next(s);
            exp_q.push_back({gap_of(s[2:0]), s[5:3]});
        end
    endtask

    task automatic pop_exp(output logic [5:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 6'bx;
    endtask

    task automatic take(output logic [5:0] col, output bit got);
        got = 1'b0;
        col = 6'bx;
        for (int i = 0; i < 40 && !got; i++) begin
            if (col_valid) begin
                got = 1'b1;
                col = {col_gap, col_aux};
                col_ready = 1'b1;
                @(negedge clk);
                col_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; restart = 1'b0; col_ready = 1'b0; force_en = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run(input logic [5:0] s);
        seed_in = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (lfsr_random !== 1'b0) begin errors++; $display("FAIL reset_lfsr_random got=%b exp=0", lfsr_random); end
        checks++; if (lfsr_load !== 1'b0) begin errors++; $display("FAIL reset_lfsr_load got=%b exp=0", lfsr_load); end
        checks++; if (lfsr_seed !== 6'd0) begin errors++; $display("FAIL reset_lfsr_seed got=%b exp=0", lfsr_seed); end
        checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL reset_col_valid got=%b exp=0", col_valid); end
        checks++; if ({col_gap, col_aux} !== 6'd0) begin errors++; $display("FAIL reset_col got=%b exp=0", {col_gap, col_aux}); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
        rst_n = 1'b1;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        checks++; if (running !== 1'b0 || lfsr_load !== 1'b0) begin
            errors++; $display("FAIL idle_restart running=%b load=%b exp=0,0", running, lfsr_load);
        end
    endtask

    task automatic test_seed_decode();
        logic [5:0] exp_states [4] = '{6'd1, 6'd2, 6'd4, 6'd8};
        logic [5:0] col, e;
        bit got;
        int lat;
        do_reset();
        push_expected(6'd1, 2);
        seed_in = 6'd1;
        start = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                checks++; if (lfsr_load !== 1'b1) begin errors++; $display("FAIL seed_load got=%b exp=1", lfsr_load); end
            end
            if (c >= 2 && c <= 5) begin
                checks++; if (lfsr_q !== exp_states[c-2]) begin
                    errors++; $display("FAIL lfsr_state c=%0d got=%b exp=%b", c, lfsr_q, exp_states[c-2]);
                end
            end
            if (col_valid && lat == 0) lat = c;
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL first_valid_latency got=%0d exp=6", lat); end
        checks++; if (lfsr_seed !== 6'd1) begin errors++; $display("FAIL seed_value got=%b exp=000001", lfsr_seed); end
        repeat (2) begin
            take(col, got); pop_exp(e);
            checks++; if (!got || col !== e) begin errors++; $display("FAIL seed_entry got=%b exp=%b", col, e); end
        end
    endtask

    task automatic test_fill_stall();
        logic [5:0] col, e, last;
        bit got;
        int rnd;
        do_reset();
        push_expected(6'd1, 6);
        start_run(6'd1);
        repeat (40) @(negedge clk);
        checks++; if (lfsr_random !== 1'b0 || col_valid !== 1'b1 || running !== 1'b1) begin
            errors++; $display("FAIL stall_park random=%b valid=%b running=%b exp=0,1,1", lfsr_random, col_valid, running);
        end
        rnd = 0;
        repeat (20) begin @(negedge clk); rnd += int'(lfsr_random); end
        checks++; if (rnd != 0) begin errors++; $display("FAIL stall_idle_steps got=%0d exp=0", rnd); end
        take(col, got); pop_exp(e);
        checks++; if (!got || col !== e) begin errors++; $display("FAIL stall_entry got=%b exp=%b", col, e); end
        rnd = 0;
        repeat (20) begin rnd += int'(lfsr_random); @(negedge clk); end
        checks++; if (rnd != 3) begin errors++; $display("FAIL single_refill_steps got=%0d exp=3", rnd); end
        col_ready = 1'b1;
        last = 6'bx;
        for (int i = 0; i < 4; i++) begin
            pop_exp(e);
            last = e;
            checks++; if (col_valid !== 1'b1 || {col_gap, col_aux} !== e) begin
                errors++; $display("FAIL back_to_back i=%0d valid=%b got=%b exp=%b", i, col_valid, {col_gap, col_aux}, e);
            end
            @(negedge clk);
        end
        checks++; if (col_valid !== 1'b0) begin errors++; $display("FAIL depth_limit valid=%b exp=0", col_valid); end
        checks++; if ({col_gap, col_aux} !== last) begin errors++; $display("FAIL hold_when_empty got=%b exp=%b", {col_gap, col_aux}, last); end
        col_ready = 1'b0;
    endtask

    task automatic test_gap_remap();
        logic [2:0] vals [3] = '{3'd7, 3'd6, 3'd5};
        logic [2:0] gaps [3] = '{3'd1, 3'd0, 3'd5};
        logic [5:0] col;
        bit got;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            force_en = 1'b1;
            force_val = vals[k];
            start_run(6'd1);
            take(col, got);
            checks++; if (!got || col[5:3] !== gaps[k]) begin
                errors++; $display("FAIL gap_remap first=%0d got=%b exp=%b", vals[k], col[5:3], gaps[k]);
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_zero_seed();
        logic [5:0] col, e;
        bit got;
        rst_n = 1'b0; restart = 1'b0; col_ready = 1'b0;
        exp_q.delete();
        seed_in = 6'd0;
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (lfsr_seed !== 6'b000001 || lfsr_load !== 1'b1) begin
            errors++; $display("FAIL zero_seed seed=%b load=%b exp=000001,1", lfsr_seed, lfsr_load);
        end
        push_expected(6'd1, 2);
        repeat (2) begin
            take(col, got); pop_exp(e);
            checks++; if (!got || col !== e) begin errors++; $display("FAIL zero_seed_entry got=%b exp=%b", col, e); end
        end
    endtask

    task automatic test_flush();
        logic [5:0] col, e;
        bit got;
        do_reset();
        start_run(6'd1);
        repeat (14) @(negedge clk);
        checks++; if (col_valid !== 1'b1) begin errors++; $display("FAIL flush_pre valid=%b exp=1", col_valid); end
        restart = 1'b1;
        col_ready = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        col_ready = 1'b0;
        checks++; if (col_valid !== 1'b0 || lfsr_load !== 1'b1) begin
            errors++; $display("FAIL flush valid=%b load=%b exp=0,1", col_valid, lfsr_load);
        end
        push_expected(6'd1, 2);
        repeat (2) begin
            take(col, got); pop_exp(e);
            checks++; if (!got || col !== e) begin errors++; $display("FAIL flush_reseed_entry got=%b exp=%b", col, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] col, e;
        bit got;
        int lat;
        do_reset();
        start_run(6'd1);
        repeat (10) @(negedge clk);
        checks++; if (lfsr_random !== 1'b1 || col_valid !== 1'b1) begin
            errors++; $display("FAIL async_pre random=%b valid=%b exp=1,1", lfsr_random, col_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (lfsr_random !== 1'b0 || col_valid !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL async_reset random=%b valid=%b running=%b exp=0,0,0", lfsr_random, col_valid, running);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        push_expected(6'd1, 2);
        seed_in = 6'd1;
        start = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (col_valid && lat == 0) lat = c;
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL async_latency got=%0d exp=6", lat); end
        repeat (2) begin
            take(col, got); pop_exp(e);
            checks++; if (!got || col !== e) begin errors++; $display("FAIL async_entry got=%b exp=%b", col, e); end
        end
    endtask

    initial begin
        test_reset();
        test_seed_decode();
        test_fill_stall();
        test_gap_remap();
        test_zero_seed();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
